// File: rtl/adc_serdes_sync.sv
// -----------------------------------------------------------------------------
// adc_serdes_sync
//
// Frame-alignment controller between the ADC ISERDES (1:8 per lane) and the
// acquisition core. It compares the deserialized frame-clock word against the
// expected pattern and issues bitslip pulses until they match. Once the word
// has matched for g_check_cycles consecutive words, it raises synced_o. It then
// keeps watching the frame and re-aligns after g_lost_threshold consecutive
// bad words.
//
// Ports
//   fs_clk_i             deserializer parallel clock, the only clock
//   fs_rst_i             synchronous reset, active-high
//   serdes_pll_locked_i  ISERDES PLL lock, asynchronous, synchronized here
//   serdes_frame_i[7:0]  deserialized frame-clock word, one per cycle
//   resync_i             single-cycle pulse, restarts alignment
//   serdes_bitslip_o     single-cycle bitslip pulse to the ISERDES
//   synced_o             frame aligned and stable
//   sync_err_o           alignment failed, held until restart
//   slip_cnt_o[7:0]      bitslips issued in the current attempt
//   lost_cnt_o[7:0]      loss-of-sync events since reset, saturating
// -----------------------------------------------------------------------------
module adc_serdes_sync #(
    parameter logic [7:0]  g_frame_pattern  = 8'h0F,
    parameter int unsigned g_settle_cycles  = 4,   // 1..15
    parameter int unsigned g_check_cycles   = 8,   // 1..255
    parameter int unsigned g_max_slips      = 16,  // 1..255
    parameter int unsigned g_lost_threshold = 4    // 1..255
) (
    input  logic       fs_clk_i,
    input  logic       fs_rst_i,
    input  logic       serdes_pll_locked_i,
    input  logic [7:0] serdes_frame_i,
    input  logic       resync_i,
    output logic       serdes_bitslip_o,
    output logic       synced_o,
    output logic       sync_err_o,
    output logic [7:0] slip_cnt_o,
    output logic [7:0] lost_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_SYNCED,
        ST_FAIL
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(g_settle_cycles - 1);
    // Cycles since the last bitslip at which another one may be requested, so
    // that consecutive pulses are at least g_settle_cycles+2 cycles apart.
    localparam logic [4:0] GAP_READY   = 5'(g_settle_cycles + 1);
    localparam logic [7:0] CHECK_N     = 8'(g_check_cycles);
    localparam logic [7:0] MAX_SLIPS   = 8'(g_max_slips);
    localparam logic [7:0] LOST_LAST   = 8'(g_lost_threshold - 1);

    state_t     state_q, state_d;
    logic       pll_meta_q, pll_ok_q;
    logic [7:0] frame_q;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic [7:0] lost_cnt_q, lost_cnt_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic [4:0] gap_cnt_q, gap_cnt_d;
    logic       frame_match;

    assign frame_match = (frame_q == g_frame_pattern);

    // -------------------------------------------------------------------------
    // Registers: lock synchronizer, frame register, FSM state and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge fs_clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of every other flop, independent of order.
        if (fs_rst_i) begin
            pll_meta_q   <= 1'b0;
            pll_ok_q     <= 1'b0;
            frame_q      <= 8'h00;
            state_q      <= ST_IDLE;
            match_cnt_q  <= 8'h00;
            slip_cnt_q   <= 8'h00;
            miss_cnt_q   <= 8'h00;
            lost_cnt_q   <= 8'h00;
            settle_cnt_q <= 4'h0;
            gap_cnt_q    <= GAP_READY;
        end else begin
            pll_meta_q   <= serdes_pll_locked_i;
            pll_ok_q     <= pll_meta_q;
            frame_q      <= serdes_frame_i;
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            lost_cnt_q   <= lost_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        lost_cnt_d   = lost_cnt_q;
        settle_cnt_d = settle_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        if (state_q == ST_SLIP) begin
            gap_cnt_d = 5'd1;
        end else if (gap_cnt_q != GAP_READY) begin
            gap_cnt_d = gap_cnt_q + 5'd1;
        end

        if (!pll_ok_q) begin
            state_d     = ST_IDLE;
            match_cnt_d = 8'h00;
            slip_cnt_d  = 8'h00;
            miss_cnt_d  = 8'h00;
        end else if (resync_i && (state_q != ST_IDLE)) begin
            // A resync in the SLIP cycle still lets that cycle's pulse out,
            // because the pulse is decoded from the current state.
            state_d     = ST_CHECK;
            match_cnt_d = 8'h00;
            slip_cnt_d  = 8'h00;
            miss_cnt_d  = 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_CHECK;
                    match_cnt_d = 8'h00;
                    slip_cnt_d  = 8'h00;
                end
                ST_CHECK: begin
                    if (match_cnt_q == CHECK_N) begin
                        state_d    = ST_SYNCED;
                        miss_cnt_d = 8'h00;
                    end else if (frame_match) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end else begin
                        match_cnt_d = 8'h00;
                        if (slip_cnt_q >= MAX_SLIPS) begin
                            state_d = ST_FAIL;
                        end else if (gap_cnt_q == GAP_READY) begin
                            state_d = ST_SLIP;
                        end
                        // Otherwise wait in CHECK until the previous slip has
                        // had time to settle (only after a resync mid-slip).
                    end
                end
                ST_SLIP: begin
                    slip_cnt_d   = slip_cnt_q + 8'd1;
                    settle_cnt_d = 4'h0;
                    state_d      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = 8'h00;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                ST_SYNCED: begin
                    if (frame_match) begin
                        miss_cnt_d = 8'h00;
                    end else if (miss_cnt_q == LOST_LAST) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = 8'h00;
                        slip_cnt_d  = 8'h00;
                        miss_cnt_d  = 8'h00;
                        if (lost_cnt_q != 8'hFF) begin
                            lost_cnt_d = lost_cnt_q + 8'd1;
                        end
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    assign serdes_bitslip_o = (state_q == ST_SLIP);
    assign synced_o         = (state_q == ST_SYNCED);
    assign sync_err_o       = (state_q == ST_FAIL);
    assign slip_cnt_o       = slip_cnt_q;
    assign lost_cnt_o       = lost_cnt_q;

endmodule

// File: tb/tb_adc_serdes_sync.sv
// -----------------------------------------------------------------------------
// tb_adc_serdes_sync
//
// Self-checking bench for adc_serdes_sync with default parameters. An ISERDES
// model rotates the frame word right by one bit on every bitslip pulse.
// Expected results come from the alignment rules: a word rotated left by k
// needs k slips and is declared synced 12+6k cycles after lock, words that
// never match fail after 16 slips, and a run of 4 bad words in SYNCED drops
// sync for a fixed window before re-alignment completes.
// -----------------------------------------------------------------------------
module tb_adc_serdes_sync;

    localparam logic [7:0] GOOD = 8'h0F;
    localparam logic [7:0] BAD  = 8'hA5;

    logic       fs_clk_i = 1'b0;
    logic       fs_rst_i;
    logic       serdes_pll_locked_i;
    logic [7:0] serdes_frame_i;
    logic       resync_i;
    logic       serdes_bitslip_o;
    logic       synced_o;
    logic       sync_err_o;
    logic [7:0] slip_cnt_o;
    logic [7:0] lost_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] word;
        int         slips;
        int         synced;
        int         err;
        int         cycles;
    } align_vec_t;

    align_vec_t vecs [8];

    adc_serdes_sync dut (
        .fs_clk_i            (fs_clk_i),
        .fs_rst_i            (fs_rst_i),
        .serdes_pll_locked_i (serdes_pll_locked_i),
        .serdes_frame_i      (serdes_frame_i),
        .resync_i            (resync_i),
        .serdes_bitslip_o    (serdes_bitslip_o),
        .synced_o            (synced_o),
        .sync_err_o          (sync_err_o),
        .slip_cnt_o          (slip_cnt_o),
        .lost_cnt_o          (lost_cnt_o)
    );

    always #5 fs_clk_i = ~fs_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] rotr8(input logic [7:0] w);
        return {w[0], w[7:1]};
    endfunction

    function automatic logic [7:0] rotl8n(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic do_reset();
        @(negedge fs_clk_i);
        fs_rst_i            = 1'b1;
        serdes_pll_locked_i = 1'b0;
        resync_i            = 1'b0;
        repeat (2) @(negedge fs_clk_i);
        fs_rst_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"}, int'(serdes_bitslip_o), 0);
        check({tag, "_synced"},  int'(synced_o), 0);
        check({tag, "_err"},     int'(sync_err_o), 0);
        check({tag, "_slipcnt"}, int'(slip_cnt_o), 0);
        check({tag, "_lostcnt"}, int'(lost_cnt_o), 0);
    endtask

    // Raise lock with the given word and run until synced or failed, acting as
    // the ISERDES (rotate right on each bitslip). Reports slips, cycles from
    // the lock edge to the outcome, and the smallest spacing between pulses.
    task automatic run_align(input logic [7:0] word, input int budget,
                             output int slips, output int cycles, output int min_gap);
        int last;
        @(negedge fs_clk_i);
        serdes_frame_i      = word;
        serdes_pll_locked_i = 1'b1;
        slips   = 0;
        cycles  = 0;
        min_gap = 1000;
        last    = -1000;
        while (cycles < budget) begin
            @(negedge fs_clk_i);
            cycles++;
            if (serdes_bitslip_o) begin
                if (slips > 0 && (cycles - last) < min_gap) min_gap = cycles - last;
                last = cycles;
                slips++;
                serdes_frame_i = rotr8(serdes_frame_i);
            end
            if (synced_o || sync_err_o) break;
        end
    endtask

    // Random good/bad word stream while SYNCED. A word driven at negedge m is
    // counted two negedges later; a completed run of 4 bad words at index b
    // holds synced low for samples b+2..b+10 and bumps lost_cnt from b+2.
    task automatic sync_burst(input int n, input int k);
        int run;
        int hold;
        int losses[$];
        int exp_sync;
        int exp_lost;
        logic [7:0] w;
        run  = 0;
        hold = 0;
        for (int m = 0; m < n; m++) begin
            if (hold > 0) begin
                w = GOOD;
                hold--;
                run = 0;
            end else if ($urandom_range(0, 99) < 45) begin
                w = GOOD ^ 8'($urandom_range(1, 255));
                run++;
                if (run == 4) begin
                    losses.push_back(m);
                    run  = 0;
                    hold = 12;
                end
            end else begin
                w = GOOD;
                run = 0;
            end
            serdes_frame_i = w;
            @(negedge fs_clk_i);
            exp_sync = 1;
            exp_lost = 0;
            foreach (losses[j]) begin
                if (losses[j] + 2 <= m + 1) exp_lost++;
                if (losses[j] + 2 <= m + 1 && m + 1 <= losses[j] + 10) exp_sync = 0;
            end
            check("burst_synced",  int'(synced_o), exp_sync);
            check("burst_lostcnt", int'(lost_cnt_o), exp_lost);
            check("burst_bitslip", int'(serdes_bitslip_o), 0);
            check("burst_slipcnt", int'(slip_cnt_o), (exp_lost > 0) ? 0 : k);
        end
        serdes_frame_i = GOOD;
    endtask

    initial begin
        int slips;
        int cycles;
        int min_gap;
        int seen;
        int lows;
        int found;
        int gap;
        int k;

        vecs[0] = '{8'h0F, 0,  1, 0, 12};
        vecs[1] = '{8'h1E, 1,  1, 0, 18};
        vecs[2] = '{8'h78, 3,  1, 0, 30};
        vecs[3] = '{8'hF0, 4,  1, 0, 36};
        vecs[4] = '{8'hE1, 5,  1, 0, 42};
        vecs[5] = '{8'h87, 7,  1, 0, 54};
        vecs[6] = '{8'h00, 16, 0, 1, 100};
        vecs[7] = '{8'hFF, 16, 0, 1, 100};

        fs_rst_i            = 1'b1;
        serdes_pll_locked_i = 1'b0;
        serdes_frame_i      = GOOD;
        resync_i            = 1'b0;

        // Reset state.
        do_reset();
        check_all_zero("reset");

        // Reset release with lock already high and an aligned frame.
        fs_rst_i            = 1'b1;
        serdes_pll_locked_i = 1'b1;
        serdes_frame_i      = GOOD;
        repeat (2) @(negedge fs_clk_i);
        fs_rst_i = 1'b0;
        seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) seen++;
            if (c == 11) check("lat_synced_c11", int'(synced_o), 0);
            if (c == 12) check("lat_synced_c12", int'(synced_o), 1);
        end
        check("lat_bitslips", seen, 0);
        check("lat_slipcnt", int'(slip_cnt_o), 0);

        // Alignment table.
        foreach (vecs[i]) begin
            do_reset();
            run_align(vecs[i].word, 400, slips, cycles, min_gap);
            check($sformatf("tbl%0d_slips", i),   slips, vecs[i].slips);
            check($sformatf("tbl%0d_synced", i),  int'(synced_o), vecs[i].synced);
            check($sformatf("tbl%0d_err", i),     int'(sync_err_o), vecs[i].err);
            check($sformatf("tbl%0d_cycles", i),  cycles, vecs[i].cycles);
            check($sformatf("tbl%0d_slipcnt", i), int'(slip_cnt_o), vecs[i].slips);
            check($sformatf("tbl%0d_gap_ge6", i), int'(min_gap >= 6), 1);
        end

        // FAIL is sticky and silent; resync with a good frame recovers.
        seen = 0;
        repeat (10) begin
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) seen++;
        end
        check("fail_no_bitslip", seen, 0);
        check("fail_err", int'(sync_err_o), 1);
        check("fail_synced", int'(synced_o), 0);
        check("fail_slipcnt", int'(slip_cnt_o), 16);
        serdes_frame_i = GOOD;
        resync_i       = 1'b1;
        @(negedge fs_clk_i);
        resync_i = 1'b0;
        check("resync_err_clr", int'(sync_err_o), 0);
        check("resync_slipcnt_clr", int'(slip_cnt_o), 0);
        for (int c = 2; c <= 10; c++) begin
            @(negedge fs_clk_i);
            if (c == 9)  check("resync_synced_c9", int'(synced_o), 0);
            if (c == 10) check("resync_synced_c10", int'(synced_o), 1);
        end

        // Three bad words are tolerated.
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            serdes_frame_i = (i < 3) ? BAD : GOOD;
            @(negedge fs_clk_i);
            if (!synced_o) lows++;
        end
        check("three_bad_sync_kept", lows, 0);
        check("three_bad_lostcnt", int'(lost_cnt_o), 0);

        // Four bad words drop sync, count a loss and re-align.
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            serdes_frame_i = (i < 4) ? BAD : GOOD;
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) seen++;
            if (i + 1 == 4)  check("four_bad_synced_n4", int'(synced_o), 1);
            if (i + 1 == 5) begin
                check("four_bad_synced_n5", int'(synced_o), 0);
                check("four_bad_lostcnt", int'(lost_cnt_o), 1);
                check("four_bad_slipcnt", int'(slip_cnt_o), 0);
            end
            if (i + 1 == 13) check("realign_synced_n13", int'(synced_o), 0);
            if (i + 1 == 14) check("realign_synced_n14", int'(synced_o), 1);
        end
        check("four_bad_no_bitslip", seen, 0);

        // One-cycle reset while SYNCED clears everything on the next edge.
        fs_rst_i = 1'b1;
        @(negedge fs_clk_i);
        fs_rst_i = 1'b0;
        check_all_zero("midrst");

        // Lock drops during SETTLE: no further slips, back to IDLE.
        do_reset();
        serdes_frame_i      = 8'h78;
        serdes_pll_locked_i = 1'b1;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) found = 1;
        end
        check("plldrop_first_slip", found, 1);
        serdes_frame_i      = rotr8(serdes_frame_i);
        serdes_pll_locked_i = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) seen++;
        end
        check("plldrop_no_bitslip", seen, 0);
        check("plldrop_synced", int'(synced_o), 0);
        check("plldrop_err", int'(sync_err_o), 0);
        check("plldrop_slipcnt", int'(slip_cnt_o), 0);
        run_align(serdes_frame_i, 400, slips, cycles, min_gap);
        check("relock_slips", slips, 2);
        check("relock_slipcnt", int'(slip_cnt_o), 2);
        check("relock_synced", int'(synced_o), 1);
        check("relock_cycles", cycles, 24);

        // Resync in the SLIP cycle: counters clear, next slip still spaced.
        do_reset();
        serdes_frame_i      = 8'h00;
        serdes_pll_locked_i = 1'b1;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge fs_clk_i);
            if (serdes_bitslip_o) found = 1;
        end
        check("slipresync_first_slip", found, 1);
        resync_i = 1'b1;
        @(negedge fs_clk_i);
        resync_i = 1'b0;
        check("slipresync_slipcnt", int'(slip_cnt_o), 0);
        check("slipresync_bitslip", int'(serdes_bitslip_o), 0);
        gap = 1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge fs_clk_i);
            gap++;
            if (serdes_bitslip_o) found = 1;
        end
        check("slipresync_next_slip", found, 1);
        check("slipresync_gap_ge6", int'(gap >= 6), 1);

        // Randomized alignment offsets followed by random bad-word bursts.
        for (int it = 0; it < 12; it++) begin
            k = int'($urandom_range(0, 7));
            do_reset();
            run_align(rotl8n(GOOD, k), 400, slips, cycles, min_gap);
            check("rnd_slips", slips, k);
            check("rnd_cycles", cycles, 12 + 6 * k);
            check("rnd_synced", int'(synced_o), 1);
            check("rnd_slipcnt", int'(slip_cnt_o), k);
            check("rnd_gap_ge6", int'(min_gap >= 6), 1);
            sync_burst(60, k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_serdes_sync.md
Name: adc_serdes_sync

Overview:
- Frame-alignment controller between the ADC deserializer (ISERDES, 1:8 per lane, fed by DCO/FR) and the acquisition core.
- Watches the deserialized frame-clock word and pulses bitslip until the word equals the expected frame pattern.
- Once aligned, it asserts synced, which drives STA.SERDES_SYNCED and gates acquisition. It keeps monitoring and re-aligns if alignment is lost.

Parameters:
- g_frame_pattern, 8'h0F, expected deserialized frame word when aligned.
- g_settle_cycles, 4, cycles to wait after a bitslip pulse before sampling the frame again (1..15).
- g_check_cycles, 8, consecutive matching words required to declare sync (1..255).
- g_max_slips, 16, bitslip pulses allowed per attempt before declaring failure (1..255).
- g_lost_threshold, 4, consecutive mismatches in SYNCED that declare loss of sync (1..255).

Ports:
- fs_clk_i  in  1  deserializer parallel clock (sampling clock / 8); the only clock.
- fs_rst_i  in  1  synchronous reset, active-high.
- serdes_pll_locked_i  in  1  deserializer PLL locked; asynchronous to fs_clk_i, double-registered internally.
- serdes_frame_i  in  8  deserialized frame-clock word, one new word per cycle.
- resync_i  in  1  single-cycle pulse; restarts alignment.
- serdes_bitslip_o  out  1  single-cycle bitslip pulse to the ISERDES.
- synced_o  out  1  frame aligned and stable.
- sync_err_o  out  1  alignment failed; sticky until restart.
- slip_cnt_o  out  8  bitslips issued in the current attempt.
- lost_cnt_o  out  8  SYNCED->loss events since reset; saturates at 255.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and all counters are 0. Reset mid-operation returns to this state on the next edge.
- pll_ok is serdes_pll_locked_i after a 2-FF synchronizer, so it lags the input by 2 cycles.
- Match test: serdes_frame_i == g_frame_pattern. The word is registered once before comparison; no other pipelining.

FSM states and transitions:
- IDLE: outputs low. Go to CHECK when pll_ok=1. On entry to CHECK, clear match_cnt and slip_cnt.
- CHECK:
  - On a match, match_cnt increments. When match_cnt reaches g_check_cycles, go to SYNCED; synced_o rises on the cycle after the g_check_cycles-th matching word is registered.
  - On a mismatch, clear match_cnt. If slip_cnt < g_max_slips, go to SLIP. Otherwise go to FAIL.
- SLIP: serdes_bitslip_o=1 for exactly one cycle, slip_cnt increments, then go to SETTLE.
- SETTLE: wait g_settle_cycles cycles, ignoring the frame, then go to CHECK (match_cnt=0, slip_cnt kept).
- SYNCED:
  - synced_o=1.
  - A mismatch increments miss_cnt; a match clears it.
  - When miss_cnt reaches g_lost_threshold: synced_o falls, lost_cnt increments (saturating), slip_cnt clears, and the FSM goes to CHECK.
  - Isolated mismatches below the threshold do not affect synced_o.
- FAIL: sync_err_o=1, synced_o=0, no bitslips. Leave only on resync_i or a pll_ok fall.

Global overrides, highest priority first:
1. fs_rst_i.
2. pll_ok=0 in any state: go to IDLE, synced_o=0, sync_err_o=0 on the next edge, and any pending bitslip is dropped.
3. resync_i=1 in any non-IDLE state: go to CHECK with match_cnt, slip_cnt, miss_cnt and sync_err_o cleared. resync_i in IDLE is ignored.

Other rules:
- resync_i coinciding with the SLIP cycle: that bitslip pulse is still issued, then resync applies on the next edge.
- Bitslip pulses are never closer than g_settle_cycles+2 cycles apart.
- slip_cnt_o holds its value in SYNCED and FAIL for status readout.

Test Plan:
- Reset release with pll_locked=1 and frame=8'h0F constant -> no bitslip; synced_o=1 exactly 2+1+8+1 cycles after the lock is seen; slip_cnt_o=0.
- Frame rotated by 3 (8'h78), with the bench model rotating one bit per bitslip -> exactly 3 bitslip pulses spaced ≥6 cycles apart, then synced_o=1 and slip_cnt_o=3.
- Frame stuck at 8'h00 -> 16 bitslips, then sync_err_o=1 and synced_o=0; a later resync_i pulse with a good frame -> sync_err_o=0 and synced_o=1 after 8 matches.
- While SYNCED: inject 3 bad words -> synced_o stays 1. Inject 4 consecutive bad words -> synced_o=0 and lost_cnt_o=1, then re-alignment proceeds.
- Drop pll_locked mid-SETTLE -> no further bitslip, IDLE, all status low; relock -> alignment restarts with slip_cnt_o=0.
- Assert fs_rst_i for 1 cycle while SYNCED -> every output 0 on the next edge; lost_cnt_o=0.
